// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped caches: FSM states, MIPS-style
// kseg0/kseg1 segment constants, and address translation helpers.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESP,
    MISS_REQ,
    MISS_FILL,
    BYP_REQ,
    BYP_WAIT
  } icache_state_t;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

  function automatic logic in_kseg01(input logic [31:0] pc);
    return ((pc & ~KSEG_MASK) == KSEG0_BASE) || ((pc & ~KSEG_MASK) == KSEG1_BASE);
  endfunction

  function automatic logic [31:0] translate(input logic [31:0] pc);
    return in_kseg01(pc) ? (pc & KSEG_MASK) : pc;
  endfunction

  function automatic logic is_uncached(input logic [31:0] pc);
    return (pc & ~KSEG_MASK) == KSEG1_BASE;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one synchronous write port for refill beats and
// one combinational read port for the same-cycle hit lookup.
module icache_data_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with kseg1 bypass, line refill over a
// burst read interface, and deferred flush while a transaction is in flight.
module icache_direct
  import icache_pkg::*;
#(
  parameter int INDEX_BITS     = 7,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic        cpu_req,
  input  logic [31:0] cpu_pc,
  output logic        cpu_ready,
  output logic [31:0] cpu_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_len,
  input  logic        mem_gnt,
  input  logic        mem_beat_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int OB    = 2 + $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 32 - OB - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int AW    = INDEX_BITS + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [31:0]      LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

  function automatic logic [OFF_W-1:0] word_off(input logic [31:0] pa);
    if (WORDS_PER_LINE > 1) return pa[2 +: OFF_W];
    return '0;
  endfunction

  icache_state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic                  flush_pend;
  logic [OFF_W-1:0]      beat_cnt;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF_W-1:0]      req_off;
  logic [31:0]           resp_word;
  logic [31:0]           rd_data;

  logic [31:0]           cpu_pa;
  logic                  cpu_unc;
  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [OFF_W-1:0]      cpu_off;
  logic                  hit, accept, cached_miss, beat, fill_beat, last_beat, clear_all;

  // Lookup: a flush in the same cycle forces the request down the miss path
  assign cpu_pa      = translate(cpu_pc);
  assign cpu_unc     = is_uncached(cpu_pc);
  assign cpu_idx     = cpu_pa[OB +: INDEX_BITS];
  assign cpu_tag     = cpu_pa[31 -: TAG_W];
  assign cpu_off     = word_off(cpu_pa);
  assign hit         = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag) && !flush;
  assign accept      = enable && (state == IDLE) && cpu_req;
  assign cached_miss = accept && !cpu_unc && !hit;
  assign beat        = enable && mem_beat_valid;
  assign fill_beat   = beat && (state == MISS_FILL);
  assign last_beat   = fill_beat && (beat_cnt == LAST_BEAT);
  assign clear_all   = enable && (((state == IDLE) && flush) ||
                                  ((state == RESP) && (flush_pend || flush)));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        IDLE:      if (cpu_req) state_nxt = cpu_unc ? BYP_REQ : (hit ? RESP : MISS_REQ);
        MISS_REQ:  if (mem_gnt) state_nxt = MISS_FILL;
        MISS_FILL: if (last_beat) state_nxt = RESP;
        BYP_REQ:   if (mem_gnt) state_nxt = BYP_WAIT;
        BYP_WAIT:  if (mem_beat_valid) state_nxt = RESP;
        RESP:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_inst  = '0;
    mem_req   = 1'b0;
    case (state)
      RESP: begin
        cpu_ready = 1'b1;
        cpu_inst  = resp_word;
      end
      MISS_REQ, BYP_REQ: mem_req = 1'b1;
      default: ;
    endcase
  end

  // Control state: valid bits, pending flush, beat counter, request outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      flush_pend <= 1'b0;
      beat_cnt   <= '0;
      miss_cnt   <= '0;
      mem_addr   <= '0;
      mem_len    <= '0;
    end else if (enable) begin
      if (clear_all)      valid          <= '0;
      else if (last_beat) valid[req_idx] <= 1'b1;

      if (state == RESP)                    flush_pend <= 1'b0;
      else if (flush && (state != IDLE))    flush_pend <= 1'b1;

      if (fill_beat) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (cached_miss) miss_cnt <= miss_cnt + 32'd1;

      if (accept && cpu_unc) begin
        mem_addr <= cpu_pa & ~32'h3;
        mem_len  <= 4'd0;
      end else if (cached_miss) begin
        mem_addr <= cpu_pa & LINE_MASK;
        mem_len  <= 4'(WORDS_PER_LINE - 1);
      end
    end
  end

  // Data state: latched request fields, response word, tags
  always_ff @(posedge clk) begin
    if (enable) begin
      if (accept) begin
        req_idx <= cpu_idx;
        req_tag <= cpu_tag;
        req_off <= cpu_off;
      end
      if (accept && !cpu_unc && hit)              resp_word <= rd_data;
      if (fill_beat && (beat_cnt == req_off))     resp_word <= mem_rdata;
      if (beat && (state == BYP_WAIT))            resp_word <= mem_rdata;
      if (last_beat)                              tag_mem[req_idx] <= req_tag;
    end
  end

  icache_data_ram #(
    .DATA_W (32),
    .AW     (AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (fill_beat && !reset),
    .waddr ({req_idx, beat_cnt}),
    .wdata (mem_rdata),
    .raddr ({cpu_idx, cpu_off}),
    .rdata (rd_data)
  );

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 The block SHALL expose parameter INDEX_BITS, default 7, log2 of the line count (128 lines).
REQ-002 The block SHALL expose parameter WORDS_PER_LINE, default 4, words per line, power of two, 1..16.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global advance; low freezes all state and outputs
- flush  in  1  invalidate all lines
- cpu_req  in  1  fetch request, sampled in IDLE
- cpu_pc  in  32  virtual fetch address; bits [1:0] ignored
- cpu_ready  out  1  one-cycle response pulse
- cpu_inst  out  32  instruction; valid only while cpu_ready is high
- mem_req  out  1  refill/bypass request; held until mem_gnt
- mem_addr  out  32  physical start address
- mem_len  out  4  number of beats minus 1
- mem_gnt  in  1  request accepted
- mem_beat_valid  in  1  one read beat present
- mem_rdata  in  32  beat data
- miss_cnt  out  32  wrapping count of cacheable misses

Function
REQ-004 Translation SHALL be: kseg0 0x8000_0000-0x9FFF_FFFF and kseg1 0xA000_0000-0xBFFF_FFFF map to pa = pc & 0x1FFF_FFFF; all other addresses pass unchanged.
REQ-005 Addresses in kseg1 SHALL be uncached; all other addresses SHALL be cached.
REQ-006 Address split SHALL be: byte [1:0]; word offset [OB-1:2] with OB = 2+log2(WORDS_PER_LINE); index [OB+INDEX_BITS-1:OB]; tag = remaining upper pa bits.
REQ-007 Per-line storage SHALL be a valid bit, a tag and WORDS_PER_LINE data words.
REQ-008 The FSM SHALL have states IDLE, RESP, MISS_REQ, MISS_FILL, BYP_REQ and BYP_WAIT.
REQ-009 In IDLE, cpu_req with a cached hit (valid and tag match) SHALL go to RESP; cpu_ready=1 with the word on the next edge, i.e. latency 1.
REQ-010 In IDLE, a cached miss SHALL go to MISS_REQ: mem_req=1, mem_addr=line-aligned pa, mem_len=WORDS_PER_LINE-1, miss_cnt+1.
REQ-011 In IDLE, an uncached request SHALL go to BYP_REQ: mem_req=1, mem_addr=pa with bits [1:0] cleared, mem_len=0.
REQ-012 While mem_req=1 and mem_gnt=1, mem_req SHALL drop on the next edge and the FSM SHALL enter MISS_FILL or BYP_WAIT.
REQ-013 In MISS_FILL, a 0..WORDS_PER_LINE-1 beat counter SHALL write each beat to the line's word[counter].
REQ-014 In MISS_FILL, the beat whose counter equals the pc word offset SHALL be latched as the response.
REQ-015 On the final MISS_FILL beat, valid and tag SHALL be written, and the FSM SHALL go to RESP with cpu_ready=1 on the next edge.
REQ-016 In BYP_WAIT, the first beat SHALL go to RESP with cpu_ready=1 and that beat's data, and the cache SHALL be unmodified.
REQ-017 RESP SHALL last exactly one cycle, clear cpu_ready and cpu_inst to 0, and return to IDLE; cpu_req is not accepted during RESP, so at least 2 cycles separate hit responses.
REQ-018 Beats arriving outside MISS_FILL and BYP_WAIT SHALL be ignored.
REQ-019 cpu_pc SHALL be latched at request acceptance; later changes to cpu_pc SHALL NOT affect an in-flight fetch.
REQ-020 A flush in IDLE SHALL clear all valid bits on that edge, and a cpu_req in the same cycle SHALL be treated as a miss.
REQ-021 A flush outside IDLE SHALL be held pending and applied on the return to IDLE, so the freshly filled line is also invalidated.
REQ-022 With enable=0, the FSM, counters, arrays and outputs SHALL hold, and mem_gnt/beats SHALL be ignored; the interface must not send beats while enable=0.

Reset
REQ-023 reset SHALL clear all valid bits, state to IDLE, cpu_ready=0, cpu_inst=0, mem_req=0, mem_addr=0, mem_len=0, miss_cnt=0, beat counter=0 and pending flush=0.
REQ-024 Reset mid-refill SHALL abandon the fill and leave no line valid, and late beats SHALL be ignored per REQ-018.

Structure
REQ-025 Package icache_pkg SHALL hold the state enum, the KSEG0/KSEG1 base and mask constants, and the translate/uncached functions shared with the data-side cache.
REQ-026 The data words SHALL live in sub-module icache_data_ram (synchronous write, combinational read); valid and tag SHALL stay in icache_direct.

Verification
REQ-027 Cold fetch 0x8000_0010 SHALL give mem_addr=0x0000_0010, mem_len=3; beats 11,22,33,44 -> cpu_inst=0x11, miss_cnt=1.
REQ-028 Repeat fetch 0x8000_0018 SHALL give cpu_ready 1 cycle after cpu_req, cpu_inst=0x33, no mem_req.
REQ-029 Fetch 0xBFC0_0000 SHALL give mem_addr=0x1FC0_0000, mem_len=0, beat 0xDEAD -> cpu_inst=0xDEAD; a repeat SHALL give mem_req again.
REQ-030 0x8000_0010 then 0x8000_0810 (same index, new tag) SHALL both miss; refetching 0x8000_0010 SHALL miss again, miss_cnt=3.
REQ-031 flush during MISS_FILL of 0x8000_0020 SHALL complete the response, and a refetch SHALL then miss.
REQ-032 reset after 2 of 4 beats SHALL give mem_req=0 and miss_cnt=0; leftover beats SHALL be ignored and a refetch SHALL miss with a full 4-beat fill.
